// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator.
// The coluna/linha counters are undelayed so they can drive address generation.
// Sync, active-area and strobe outputs pass through an en-gated register
// pipeline, which lines them up with a downstream pixel pipeline.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 10,
    parameter int PIPE_DELAY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] coluna,
    output logic [CNT_W-1:0] linha,
    output logic             h_sync,
    output logic             v_sync,
    output logic             regiao_ativa,
    output logic             inicio_linha,
    output logic             inicio_quadro
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Pipeline stage layout: {h level, v level, active, line strobe, frame strobe}.
    // Sync bits are stored already polarised so the outputs come straight from flops.
    typedef logic [4:0] stage_t;
    localparam stage_t STAGE_RST = {~H_SYNC_POL, ~V_SYNC_POL, 3'b000};

    logic [CNT_W-1:0] coluna_q, coluna_d;
    logic [CNT_W-1:0] linha_q, linha_d;
    stage_t           stage_q [PIPE_DELAY];
    stage_t           stage_d [PIPE_DELAY];
    stage_t           raw;

    // Next counter values: column wraps at end of line and advances the line.
    always_comb begin
        coluna_d = coluna_q;
        linha_d  = linha_q;
        if (en) begin
            if (coluna_q == H_LAST) begin
                coluna_d = '0;
                linha_d  = (linha_q == V_LAST) ? '0 : linha_q + CNT_W'(1);
            end else begin
                coluna_d = coluna_q + CNT_W'(1);
            end
        end
    end

    // Raw timing decode from the current (undelayed) counters.
    always_comb begin
        logic h_raw, v_raw, act_raw, ls_raw, fs_raw;
        h_raw   = (coluna_q >= H_SYNC_START) && (coluna_q <= H_SYNC_END);
        v_raw   = (linha_q >= V_SYNC_START) && (linha_q <= V_SYNC_END);
        act_raw = (coluna_q < H_VIS) && (linha_q < V_VIS);
        ls_raw  = (coluna_q == '0);
        fs_raw  = (coluna_q == '0) && (linha_q == '0);
        raw     = {h_raw ? H_SYNC_POL : ~H_SYNC_POL,
                   v_raw ? V_SYNC_POL : ~V_SYNC_POL,
                   act_raw, ls_raw, fs_raw};
    end

    // Shift the pipeline by one stage on each enabled cycle.
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Counter and pipeline registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coluna_q <= '0;
            linha_q  <= '0;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                stage_q[i] <= STAGE_RST;
            end
        end else begin
            coluna_q <= coluna_d;
            linha_q  <= linha_d;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign coluna        = coluna_q;
    assign linha         = linha_q;
    assign h_sync        = stage_q[PIPE_DELAY-1][4];
    assign v_sync        = stage_q[PIPE_DELAY-1][3];
    assign regiao_ativa  = stage_q[PIPE_DELAY-1][2];
    // Strobes are gated so they never show during a held (en=0) cycle.
    assign inicio_linha  = stage_q[PIPE_DELAY-1][1] & en;
    assign inicio_quadro = stage_q[PIPE_DELAY-1][0] & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] lin;
        logic       hs;
        logic       vs;
        logic       act;
        logic       ls;
        logic       fs;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic clk = 1'b0;
    logic reset;
    logic en;

    logic [3:0] col_a, lin_a;
    logic       hs_a, vs_a, act_a, ls_a, fs_a;
    logic [9:0] col_b, lin_b;
    logic       hs_b, vs_b, act_b, ls_b, fs_b;

    int   n_checks = 0;
    int   n_errors = 0;
    int   t        = 0;
    bit   stim_done = 1'b0;
    pair_t sb_q[$];

    always #5 clk = ~clk;

    // Small config: 14 x 7, active-high syncs, three-stage pipeline.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(4), .PIPE_DELAY(3)
    ) dut_a (
        .clk(clk), .reset(reset), .en(en),
        .coluna(col_a), .linha(lin_a), .h_sync(hs_a), .v_sync(vs_a),
        .regiao_ativa(act_a), .inicio_linha(ls_a), .inicio_quadro(fs_a)
    );

    // Default horizontal timing with a short frame, active-low syncs, one stage.
    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(10), .PIPE_DELAY(1)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en),
        .coluna(col_b), .linha(lin_b), .h_sync(hs_b), .v_sync(vs_b),
        .regiao_ativa(act_b), .inicio_linha(ls_b), .inicio_quadro(fs_b)
    );

    // Reference: after t enabled edges the counters sit at pixel t of an endless
    // raster, and the delayed outputs describe pixel t-pd (reset values before that).
    function automatic exp_t model(input int tt, input bit e,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp, input int pd);
        exp_t r;
        int ht, vt, n, c, l;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        r.col = 10'(tt % ht);
        r.lin = 10'((tt / ht) % vt);
        if (tt < pd) begin
            r.hs = ~hp; r.vs = ~vp; r.act = 1'b0; r.ls = 1'b0; r.fs = 1'b0;
        end else begin
            n = tt - pd;
            c = n % ht;
            l = (n / ht) % vt;
            r.hs  = (c >= ha + hf && c < ha + hf + hsw) ? hp : ~hp;
            r.vs  = (l >= va + vf && l < va + vf + vsw) ? vp : ~vp;
            r.act = (c < ha) && (l < va);
            r.ls  = (c == 0) && e;
            r.fs  = (c == 0) && (l == 0) && e;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    task automatic cmp(input string tag, input exp_t got, input exp_t want);
        chk({tag, ".coluna"},        got.col,        want.col);
        chk({tag, ".linha"},         got.lin,        want.lin);
        chk({tag, ".h_sync"},        10'(got.hs),    10'(want.hs));
        chk({tag, ".v_sync"},        10'(got.vs),    10'(want.vs));
        chk({tag, ".regiao_ativa"},  10'(got.act),   10'(want.act));
        chk({tag, ".inicio_linha"},  10'(got.ls),    10'(want.ls));
        chk({tag, ".inicio_quadro"}, 10'(got.fs),    10'(want.fs));
    endtask

    function automatic exp_t got_a();
        exp_t g;
        g = {{6'd0, col_a}, {6'd0, lin_a}, hs_a, vs_a, act_a, ls_a, fs_a};
        return g;
    endfunction

    function automatic exp_t got_b();
        exp_t g;
        g = {col_b, lin_b, hs_b, vs_b, act_b, ls_b, fs_b};
        return g;
    endfunction

    // One clock of stimulus; the expected view of that cycle goes to the scoreboard.
    task automatic cycle(input bit e, input bit r);
        pair_t p;
        @(negedge clk);
        en    = e;
        reset = r;
        p.a = model(t, e, 8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b1, 3);
        p.b = model(t, e, 640, 16, 96, 48, 4, 1, 1, 1, 1'b0, 1'b0, 1);
        sb_q.push_back(p);
        @(posedge clk);
        if (e && r) t++;
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                p = sb_q.pop_front();
                cmp("a", got_a(), p.a);
                cmp("b", got_b(), p.b);
            end
        end
    end

    // Stimulus sequence.
    initial begin
        reset = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'($urandom_range(0, 1)), 1'b0);
        t = 0;
        for (int i = 0; i < 7000; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 6000; i++) cycle(1'($urandom_range(0, 3) != 0), 1'b1);

        // Asynchronous reset between edges, mid-line.
        for (int i = 0; i < 800 && (t % 800) != 300; i++) cycle(1'b1, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        chk("async.coluna_a", {6'd0, col_a}, 10'd0);
        chk("async.linha_a",  {6'd0, lin_a}, 10'd0);
        chk("async.h_sync_a", 10'(hs_a), 10'd0);
        chk("async.v_sync_a", 10'(vs_a), 10'd0);
        chk("async.coluna_b", col_b, 10'd0);
        chk("async.linha_b",  lin_b, 10'd0);
        chk("async.h_sync_b", 10'(hs_b), 10'd1);
        chk("async.v_sync_b", 10'(vs_b), 10'd1);
        chk("async.ativa_b",  10'(act_b), 10'd0);
        chk("async.strobes_b", 10'({ls_b, fs_b}), 10'd0);
        chk("async.strobes_a", 10'({act_a, ls_a, fs_a}), 10'd0);
        t = 0;
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) cycle(1'(i % 2 == 0), 1'b1);
        for (int i = 0; i < 3000; i++) cycle(1'($urandom_range(0, 1)), 1'b1);

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #5;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
